// File: rtl/wave_cap_pkg.sv
// Shared types and constants for the wave capture controller.
package wave_cap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST_FILL,
        HOLD
    } cap_state_e;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_AUTO   = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;
    localparam logic [1:0] MODE_STOP   = 2'd3;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/wave_capture_ctrl_if.sv
// Wave RAM write port plus the frozen-buffer status seen by the display side.
interface wave_capture_ctrl_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
);
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] start_addr;
    logic              buf_ready;

    modport master (output ram_we, ram_waddr, ram_wdata, start_addr, buf_ready);
    modport slave  (input  ram_we, ram_waddr, ram_wdata, start_addr, buf_ready);
endinterface

// File: rtl/wave_capture_ctrl_trig.sv
// Level/slope trigger: remembers the previous ticked sample and flags a crossing on a tick.
module wave_trig_detect
    import wave_cap_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [DATA_W-1:0] level_i,
    input  logic              slope_i,
    output logic              trig_o
);
    logic [DATA_W-1:0] prev_q;
    logic              rise_hit;
    logic              fall_hit;

    assign rise_hit = (prev_q <  level_i) && (sample_i >= level_i);
    assign fall_hit = (prev_q >= level_i) && (sample_i <  level_i);
    assign trig_o   = tick_i && ((slope_i == SLOPE_FALL) ? fall_hit : rise_hit);

    // Previous sample advances on every tick, independent of capture state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         prev_q <= '0;
        else if (tick_i) prev_q <= sample_i;
    end
endmodule

// File: rtl/wave_capture_ctrl.sv
// Wave capture sequencer: sample decimation, pre-trigger window, freeze-until-frame, re-arm.
// Optional feature: define WAVE_CAP_AUTO_EN to force a capture after AUTO_TMO idle ticks in AUTO mode.
module wave_capture_ctrl
    import wave_cap_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 600,
    parameter int PRETRIG  = 100,
    parameter int DIV_W    = 16,
    parameter int AUTO_TMO = 4096
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DIV_W-1:0]  sample_div,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic              frame_done,
    wave_capture_ctrl_if.master wif,
    output logic              cap_busy,
    output logic              trig_seen
);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 2);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   OLD_OFS   = (ADDR_W+1)'(DEPTH - PRETRIG);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);

    if (PRETRIG < 1 || PRETRIG >= DEPTH - 1 || AUTO_TMO < 1) begin : g_bad_params
        $error("wave_capture_ctrl: PRETRIG must lie in 1..DEPTH-2 and AUTO_TMO must be positive");
    end

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + 1'b1;
    endfunction

    // Oldest sample sits DEPTH-PRETRIG slots after the trigger write, modulo DEPTH.
    function automatic logic [ADDR_W-1:0] oldest_addr(input logic [ADDR_W-1:0] t);
        logic [ADDR_W:0] sum;
        sum = {1'b0, t} + OLD_OFS;
        if (sum >= DEPTH_X) sum = sum - DEPTH_X;
        return sum[ADDR_W-1:0];
    endfunction

    cap_state_e        state_q;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d, div_max;
    logic              tick, trig, timeout;
    logic [ADDR_W-1:0] wr_addr_q, cnt_q, trig_addr_q, start_addr_q, waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q, buf_ready_q, trig_seen_q;

    assign div_max   = (sample_div == '0) ? '0 : sample_div - DIV_W'(1);
    assign tick      = (div_cnt_q >= div_max);
    assign div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);

    // Free-running decimation counter; tick when it wraps.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) div_cnt_q <= '0;
        else     div_cnt_q <= div_cnt_d;
    end

    wave_trig_detect #(.DATA_W(DATA_W)) u_trig (
        .clk      (clk_50m),
        .rst      (rst),
        .tick_i   (tick),
        .sample_i (adc_data),
        .level_i  (trig_level),
        .slope_i  (trig_slope),
        .trig_o   (trig)
    );

`ifdef WAVE_CAP_AUTO_EN
    localparam int TMO_W = $clog2(AUTO_TMO + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             auto_q;

    assign timeout = auto_q && (tmo_q == TMO_W'(AUTO_TMO - 1));

    // Timeout ticks counted only while waiting; mode latched at the IDLE/HOLD decision points.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            tmo_q  <= '0;
            auto_q <= 1'b0;
        end else begin
            if (state_q != WAIT_TRIG) tmo_q <= '0;
            else if (tick)            tmo_q <= tmo_q + 1'b1;
            if (state_q == IDLE || state_q == HOLD) auto_q <= (mode == MODE_AUTO);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Capture FSM with registered RAM write port and status outputs.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            cnt_q        <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            buf_ready_q  <= 1'b0;
            trig_seen_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mode == MODE_NORMAL || mode == MODE_AUTO || (mode == MODE_SINGLE && arm)) begin
                        state_q     <= PRE_FILL;
                        cnt_q       <= '0;
                        buf_ready_q <= 1'b0;
                    end
                end
                PRE_FILL, WAIT_TRIG, POST_FILL: begin
                    if (tick) begin
                        if (mode == MODE_STOP) begin
                            state_q <= IDLE;
                        end else begin
                            we_q      <= 1'b1;
                            waddr_q   <= wr_addr_q;
                            wdata_q   <= adc_data;
                            wr_addr_q <= next_addr(wr_addr_q);
                            cnt_q     <= cnt_q + 1'b1;
                            if (state_q == PRE_FILL) begin
                                if (cnt_q == PRE_LAST) begin
                                    state_q <= WAIT_TRIG;
                                    cnt_q   <= '0;
                                end
                            end else if (state_q == WAIT_TRIG) begin
                                if (trig || timeout) begin
                                    trig_addr_q <= wr_addr_q;
                                    trig_seen_q <= trig;
                                    state_q     <= POST_FILL;
                                    cnt_q       <= '0;
                                end
                            end else if (cnt_q == POST_LAST) begin
                                start_addr_q <= oldest_addr(trig_addr_q);
                                buf_ready_q  <= 1'b1;
                                state_q      <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (frame_done) begin
                        if (mode == MODE_SINGLE || mode == MODE_STOP) begin
                            state_q <= IDLE;
                        end else begin
                            state_q     <= PRE_FILL;
                            cnt_q       <= '0;
                            buf_ready_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wif.ram_we     = we_q;
    assign wif.ram_waddr  = waddr_q;
    assign wif.ram_wdata  = wdata_q;
    assign wif.start_addr = start_addr_q;
    assign wif.buf_ready  = buf_ready_q;
    assign cap_busy       = (state_q == PRE_FILL) || (state_q == WAIT_TRIG) || (state_q == POST_FILL);
    assign trig_seen      = trig_seen_q;
endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl with DEPTH=16, PRETRIG=4, AUTO_TMO=8.
module tb_wave_capture_ctrl;
    localparam int DATA_W = 10, ADDR_W = 10, DEPTH = 16, PRETRIG = 4, DIV_W = 16, AUTO_TMO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] adc = '0;
    logic [DIV_W-1:0]  sdiv = 16'd2;
    logic [DATA_W-1:0] level = '0;
    logic              slope = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              arm = 1'b0;
    logic              frame_done = 1'b0;
    logic              cap_busy, trig_seen;

    int  n_run = 0, n_fail = 0;
    int  cyc = 0;
    bit  ramp_on = 0, ramp_up = 1;

    logic [DATA_W-1:0] mem [16];
    int  nwr = 0;
    int  first_addr = -1;
    bit  first_seen = 0;

    always #5 clk = ~clk;

    wave_capture_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wif ();

    wave_capture_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PRETRIG(PRETRIG),
        .DIV_W(DIV_W), .AUTO_TMO(AUTO_TMO)
    ) dut (
        .clk_50m    (clk),
        .rst        (rst),
        .adc_data   (adc),
        .sample_div (sdiv),
        .trig_level (level),
        .trig_slope (slope),
        .mode       (mode),
        .arm        (arm),
        .frame_done (frame_done),
        .wif        (wif),
        .cap_busy   (cap_busy),
        .trig_seen  (trig_seen)
    );

    // Shadow RAM built from the observed write port.
    always @(negedge clk) begin
        if (rst) begin
            first_seen <= 0;
        end else if (wif.ram_we) begin
            mem[wif.ram_waddr[3:0]] <= wif.ram_wdata;
            nwr <= nwr + 1;
            if (!first_seen) begin
                first_seen <= 1;
                first_addr <= int'(wif.ram_waddr);
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_run++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rd(input int a);
        logic [3:0] i;
        i = 4'(a % 16);
        return int'(mem[i]);
    endfunction

    // Advance n cycles; the ramp steps every second cycle so each 2-cycle tick sees a new value.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (ramp_on && (cyc % 2 == 0)) begin
                if (ramp_up)        adc = adc + 1'b1;
                else if (adc != '0) adc = adc - 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        ramp_on = 0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int bound, input string tag);
        for (int i = 0; i < bound && !wif.buf_ready; i++) step(1);
        check(tag, int'(wif.buf_ready), 1);
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        step(1);
        frame_done = 1'b0;
    endtask

    int s, n0;

    initial begin
        // Reset state
        step(2);
        check("rst_we", int'(wif.ram_we), 0);
        check("rst_waddr", int'(wif.ram_waddr), 0);
        check("rst_wdata", int'(wif.ram_wdata), 0);
        check("rst_start", int'(wif.start_addr), 0);
        check("rst_ready", int'(wif.buf_ready), 0);
        check("rst_busy", int'(cap_busy), 0);
        check("rst_tseen", int'(trig_seen), 0);

        // 1: rising ramp, level 10, NORMAL
        mode = 2'd0; sdiv = 16'd2; level = 10'd10; slope = 1'b0; adc = '0; ramp_up = 1;
        do_reset();
        ramp_on = 1;
        wait_ready(300, "t1_ready");
        step(3);
        s = int'(wif.start_addr);
        check("t1_tseen", int'(trig_seen), 1);
        check("t1_oldest", rd(s), 6);
        check("t1_pre_last", rd(s + 3), 9);
        check("t1_trig_pt", rd(s + 4), 10);
        check("t1_newest", rd(s + 15), 21);
        n0 = nwr;
        step(40);
        check("t1_hold_silent", nwr - n0, 0);
        check("t1_hold_ready", int'(wif.buf_ready), 1);
        check("t1_hold_busy", int'(cap_busy), 0);
        pulse_frame();
        check("t1_rearm_ready", int'(wif.buf_ready), 0);
        check("t1_rearm_busy", int'(cap_busy), 1);

        // 2: sample_div 0, 1 and 2 with a constant input (never triggers)
        ramp_on = 0; adc = 10'd3; sdiv = 16'd0;
        do_reset();
        step(10); n0 = nwr; step(10);
        check("t2_div0", nwr - n0, 10);
        sdiv = 16'd1; step(4); n0 = nwr; step(10);
        check("t2_div1", nwr - n0, 10);
        sdiv = 16'd2; step(4); n0 = nwr; step(10);
        check("t2_div2", nwr - n0, 5);

        // 3: falling ramp 15 down, level 5
        sdiv = 16'd2; level = 10'd5; slope = 1'b1; adc = 10'd15; ramp_up = 0;
        do_reset();
        ramp_on = 1;
        wait_ready(300, "t3_ready");
        step(3);
        s = int'(wif.start_addr);
        check("t3_tseen", int'(trig_seen), 1);
        check("t3_oldest", rd(s), 8);
        check("t3_pre_last", rd(s + 3), 5);
        check("t3_trig_pt", rd(s + 4), 4);
        check("t3_newest", rd(s + 15), 0);

        // 3b: the only crossing falls inside PRE_FILL and must be ignored
        level = 10'd14; adc = 10'd15;
        do_reset();
        ramp_on = 1;
        step(200);
        check("t3b_no_ready", int'(wif.buf_ready), 0);
        check("t3b_busy", int'(cap_busy), 1);

        // 4: SINGLE mode waits for arm, holds the result in IDLE, recaptures on a second arm
        mode = 2'd2; level = 10'd10; slope = 1'b0; adc = '0; ramp_up = 1;
        do_reset();
        n0 = nwr; step(30);
        check("t4_no_arm_wr", nwr - n0, 0);
        check("t4_no_arm_busy", int'(cap_busy), 0);
        adc = '0; ramp_on = 1; arm = 1'b1; step(1); arm = 1'b0;
        check("t4_armed_busy", int'(cap_busy), 1);
        wait_ready(300, "t4_ready1");
        step(3);
        s = int'(wif.start_addr);
        check("t4_trig_pt", rd(s + 4), 10);
        pulse_frame(); step(1);
        check("t4_idle_busy", int'(cap_busy), 0);
        check("t4_idle_ready", int'(wif.buf_ready), 1);
        n0 = nwr; step(20);
        check("t4_idle_wr", nwr - n0, 0);
        adc = '0; arm = 1'b1; step(1); arm = 1'b0;
        check("t4_rearm_ready", int'(wif.buf_ready), 0);
        wait_ready(300, "t4_ready2");

        // 5: AUTO with constant input
        mode = 2'd1; ramp_on = 0; adc = 10'd3; level = 10'd10;
        do_reset();
`ifdef WAVE_CAP_AUTO_EN
        wait_ready(300, "t5_auto_ready");
        check("t5_auto_tseen", int'(trig_seen), 0);
`else
        step(200);
        check("t5_no_ready", int'(wif.buf_ready), 0);
        check("t5_busy", int'(cap_busy), 1);
`endif

        // 6: async reset during POST_FILL
        mode = 2'd0; adc = '0; ramp_up = 1;
        do_reset();
        ramp_on = 1;
        for (int i = 0; i < 300 && !(wif.ram_we && wif.ram_wdata == 10'd12); i++) step(1);
        check("t6_reach_post", int'(wif.ram_wdata), 12);
        check("t6_pre_tseen", int'(trig_seen), 1);
        ramp_on = 0;
        #1 rst = 1'b1;
        #1;
        check("t6_we", int'(wif.ram_we), 0);
        check("t6_waddr", int'(wif.ram_waddr), 0);
        check("t6_wdata", int'(wif.ram_wdata), 0);
        check("t6_busy", int'(cap_busy), 0);
        check("t6_tseen", int'(trig_seen), 0);
        check("t6_start", int'(wif.start_addr), 0);
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 50 && !first_seen; i++) step(1);
        check("t6_first_seen", int'(first_seen), 1);
        check("t6_first_addr", first_addr, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
